alu_share_sched: RTL

Two-port scheduler that shares the single EX-stage ALU between two requesters, port 0 (pipeline EX issue) and port 1 (auxiliary/iterative unit). It arbitrates valid/ready requests and drives the ALU control and operand inputs from a registered issue stage. It captures the ALU result and zero flag into a buffered response stage tagged with the requester id. It sits between the requesters and the combinational ALU; the ALU itself is external.

---
 rtl/alu_share_sched.sv | 96 +++++++++
 1 files changed

// File: rtl/alu_share_sched.sv
// alu_share_sched: shares one external ALU between two valid/ready ports through an issue register (S1) and a response register (S2). Define ALU_SCHED_RR_EN for round-robin; otherwise port 0 wins fixed priority.
module alu_share_sched #(
  parameter int W  = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_valid,
  input  logic [3:0]    r0_ctrl,
  input  logic [W-1:0]  r0_a,
  input  logic [W-1:0]  r0_b,
  output logic          r0_ready,
  input  logic          r1_valid,
  input  logic [3:0]    r1_ctrl,
  input  logic [W-1:0]  r1_a,
  input  logic [W-1:0]  r1_b,
  output logic          r1_ready,
  output logic [3:0]    alu_ctrl,
  output logic [W-1:0]  alu_in1,
  output logic [W-1:0]  alu_in2,
  input  logic [W-1:0]  alu_op,
  input  logic          alu_zero,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [W-1:0]  rsp_result,
  output logic          rsp_zero,
  output logic [CW-1:0] op_count
);
  logic          s1_valid, s1_id;
  logic [3:0]    s1_ctrl;
  logic [W-1:0]  s1_a, s1_b;
  logic          s2_valid, s2_id, s2_zero;
  logic [W-1:0]  s2_result;
  logic          s2_free, s1_free, g0, g1, acc, adv, rsp_fire;
`ifdef ALU_SCHED_RR_EN
  logic ptr;
  always_comb begin
    g0 = r0_valid & (!r1_valid | ptr);
    g1 = r1_valid & (!r0_valid | !ptr);
  end
  always_ff @(posedge clk)
    if (reset) ptr <= 1'b1;
    else if (acc) ptr <= r1_ready;
`else
  always_comb begin
    g0 = r0_valid;
    g1 = r1_valid & !r0_valid;
  end
`endif
  always_comb begin
    s2_free  = !s2_valid | rsp_ready;
    s1_free  = !s1_valid | s2_free;
    r0_ready = g0 & s1_free & !reset;
    r1_ready = g1 & s1_free & !reset;
    acc      = r0_ready | r1_ready;
    adv      = s1_valid & s2_free;
    rsp_fire = s2_valid & rsp_ready;
  end
  always_ff @(posedge clk)
    if (reset) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (acc) begin
      s1_valid <= 1'b1;
      s1_id    <= r1_ready;
      s1_ctrl  <= r1_ready ? r1_ctrl : r0_ctrl;
      s1_a     <= r1_ready ? r1_a : r0_a;
      s1_b     <= r1_ready ? r1_b : r0_b;
    end else if (adv) s1_valid <= 1'b0;
  always_ff @(posedge clk)
    if (reset) begin
      s2_valid  <= 1'b0;
      s2_id     <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
    end else if (adv) begin
      s2_valid  <= 1'b1;
      s2_id     <= s1_id;
      s2_result <= alu_op;
      s2_zero   <= alu_zero;
    end else if (rsp_fire) s2_valid <= 1'b0;
  always_ff @(posedge clk)
    if (reset) op_count <= '0;
    else if (rsp_fire) op_count <= op_count + 1'b1;
  assign alu_ctrl   = s1_ctrl;
  assign alu_in1    = s1_a;
  assign alu_in2    = s1_b;
  assign rsp_valid  = s2_valid;
  assign rsp_id     = s2_id;
  assign rsp_result = s2_result;
  assign rsp_zero   = s2_zero;
endmodule
